// File: rtl/aidan_mcnay_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
// Valid/ready handshake on both sides; one transaction in flight at a time.
module aidan_mcnay_div #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] opa,
  input  logic [nbits-1:0] opb,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] result,
  output logic             ostream_val,
  input  logic             ostream_rdy
);

  localparam int CW = $clog2(nbits + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [nbits:0]   rem_q, rem_d;
  logic [nbits-1:0] quo_q, quo_d;
  logic [nbits-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             irdy_q, irdy_d;
  logic             oval_q, oval_d;

  logic [nbits:0]   shifted;
  logic [nbits:0]   diff;

  // The dividend register doubles as the quotient: bits shift out the top
  // into the remainder while quotient bits shift in at the bottom.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q[nbits-1:0], quo_q[nbits-1]};
    diff    = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (istream_val) begin
          rem_d   = '0;
          quo_d   = opa;
          dvs_d   = opb;
          cnt_d   = CW'(nbits);
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor always "fits", which yields the all-ones quotient.
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = diff;
          quo_d = {quo_q[nbits-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[nbits-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    irdy_d = (state_d == IDLE);
    oval_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      irdy_q  <= 1'b1;
      oval_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together from pre-edge values.
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      irdy_q  <= irdy_d;
      oval_q  <= oval_d;
    end
  end

  assign istream_rdy = irdy_q;
  assign ostream_val = oval_q;
  assign result      = quo_q;

endmodule

// File: tb/tb_aidan_mcnay_div.sv
// Self-checking bench for aidan_mcnay_div: directed corner cases, reset
// abort, back-pressure, randomized traffic, and an 8-bit instance.
module tb_aidan_mcnay_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] opa, opb, result;
  logic        istream_val, istream_rdy, ostream_val, ostream_rdy;

  logic [7:0]  opa8, opb8, result8;
  logic        ival8, irdy8, oval8, ordy8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aidan_mcnay_div #(.nbits(32)) dut (
    .clk(clk), .reset(reset), .opa(opa), .opb(opb),
    .istream_val(istream_val), .istream_rdy(istream_rdy),
    .result(result), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy)
  );

  aidan_mcnay_div #(.nbits(8)) dut8 (
    .clk(clk), .reset(reset), .opa(opa8), .opb(opb8),
    .istream_val(ival8), .istream_rdy(irdy8),
    .result(result8), .ostream_val(oval8), .ostream_rdy(ordy8)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, verify latency, hold the result for `stall` cycles,
  // then complete the output handshake and verify the return to IDLE.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    int          lat;
    logic        rdy_bad;
    logic        hold_bad;
    logic [31:0] exp;
    exp = model(a, b);
    @(negedge clk);
    chk({tag, ".rdy_before"}, {31'd0, istream_rdy}, 32'd1);
    opa = a; opb = b; istream_val = 1'b1; ostream_rdy = 1'b0;
    @(posedge clk); #1;
    // Garbage inputs while busy must be ignored.
    opa = $urandom; opb = $urandom; istream_val = 1'b1;
    lat = 0; rdy_bad = 1'b0;
    while (!ostream_val && lat < 40) begin
      if (istream_rdy) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    istream_val = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'd32);
    chk({tag, ".rdy_busy"}, {31'd0, rdy_bad | istream_rdy}, 32'd0);
    chk({tag, ".result"}, result, exp);
    hold_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (result !== exp || !ostream_val || istream_rdy) hold_bad = 1'b1;
    end
    if (stall > 0) chk({tag, ".hold"}, {31'd0, hold_bad}, 32'd0);
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
    chk({tag, ".idle_rdy"}, {30'd0, istream_rdy, ostream_val}, 32'd2);
  endtask

  int          n_done;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; opa = '0; opb = '0; istream_val = 1'b0; ostream_rdy = 1'b0;
    opa8 = '0; opb8 = '0; ival8 = 1'b0; ordy8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdy", {31'd0, istream_rdy}, 32'd1);
    chk("reset.val", {31'd0, ostream_val}, 32'd0);
    chk("reset.result", result, 32'd0);
    reset = 1'b0;

    do_op("d100_7", 32'd100, 32'd7, 0);
    do_op("d5_0", 32'd5, 32'd0, 0);
    do_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 0);
    do_op("d3_10", 32'd3, 32'd10, 0);
    do_op("d42_42", 32'd42, 32'd42, 0);
    do_op("d0_0", 32'd0, 32'd0, 0);
    do_op("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("d1000_10", 32'd1000, 32'd10, 10);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    opa = 32'd77; opb = 32'd3; istream_val = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midcalc.rdy", {31'd0, istream_rdy}, 32'd1);
    chk("midcalc.val", {31'd0, ostream_val}, 32'd0);
    chk("midcalc.result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (ostream_val) seen = 1'b1;
      end
      chk("midcalc.no_val", {31'd0, seen}, 32'd0);
    end
    do_op("d81_9", 32'd81, 32'd9, 0);

    // Reset while holding a result in DONE.
    @(negedge clk);
    opa = 32'd9; opb = 32'd2; istream_val = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    chk("done.val_before", {31'd0, ostream_val}, 32'd1);
    reset = 1'b1;
    #1;
    chk("done.reset", {30'd0, istream_rdy, ostream_val}, 32'd2);
    chk("done.result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic with idle gaps and output stalls.
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 255);
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op($sformatf("rand%0d", k), ra, rb, $urandom_range(0, 4));
      n_done++;
    end
    chk("rand.count", 32'(n_done), 32'd40);

    // 8-bit instance.
    @(negedge clk);
    opa8 = 8'd255; opb8 = 8'd16; ival8 = 1'b1;
    @(posedge clk); #1;
    ival8 = 1'b0;
    begin
      int lat8;
      lat8 = 0;
      while (!oval8 && lat8 < 20) begin
        @(posedge clk); #1;
        lat8++;
      end
      chk("n8.latency", 32'(lat8), 32'd8);
    end
    chk("n8.result", {24'd0, result8}, 32'd15);
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
    chk("n8.idle", {30'd0, irdy8, oval8}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
